// File: rtl/vi_crop_pack.sv
`default_nettype none
// ============================================================================
// Module   : vi_crop_pack
// Purpose  : Crops a window from an RGB565 pixel stream, packs pixel pairs
//            into 32-bit words and buffers them in a FWFT valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module vi_crop_pack #(
    parameter int FIFO_AW = 4,
    parameter int CW      = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vi_vs,
    input  logic          vi_de,
    input  logic [15:0]   vi_data,
    input  logic          capture_en,
    input  logic [CW-1:0] win_x,
    input  logic [CW-1:0] win_y,
    input  logic [CW-1:0] win_w,
    input  logic [CW-1:0] win_h,
    output logic [31:0]   m_data,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          frame_done,
    output logic          overflow,
    output logic          busy
);

    localparam int             c_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [CW:0]    c_ONE   = (CW+1)'(1);

    // ------------------------------------------------------------------
    // Frame / line edge detection
    // ------------------------------------------------------------------
    logic r_vs_d;
    logic r_de_d;
    logic w_vs_rise;
    logic w_de_fall;

    assign w_vs_rise = vi_vs && !r_vs_d;
    assign w_de_fall = r_de_d && !vi_de;

    // ------------------------------------------------------------------
    // Shadow window, counters, packing state
    // ------------------------------------------------------------------
    logic [CW-1:0] r_sx;
    logic [CW-1:0] r_sy;
    logic [CW-1:0] r_sw;
    logic [CW-1:0] r_sh;
    logic          r_busy;
    logic [CW-1:0] r_x_cnt;
    logic [CW-1:0] r_y_cnt;
    logic          r_hold_vld;
    logic [15:0]   r_hold_data;
    logic          r_first;
    logic          r_frame_done;

    logic          r_wd_vld;
    logic [31:0]   r_wd_data;
    logic          r_wd_sof;
    logic          r_wd_eol;
    logic          r_wd_last;

    logic [CW:0]   w_x_ext;
    logic [CW:0]   w_y_ext;
    logic [CW:0]   w_x_end;
    logic [CW:0]   w_y_end;
    logic          w_in_x;
    logic          w_in_y;
    logic          w_in_win;
    logic          w_line_last;
    logic          w_last_line;

    // One extra bit so win_x+win_w never wraps
    assign w_x_ext     = {1'b0, r_x_cnt};
    assign w_y_ext     = {1'b0, r_y_cnt};
    assign w_x_end     = {1'b0, r_sx} + {1'b0, r_sw};
    assign w_y_end     = {1'b0, r_sy} + {1'b0, r_sh};
    assign w_in_x      = (w_x_ext >= {1'b0, r_sx}) && (w_x_ext < w_x_end);
    assign w_in_y      = (w_y_ext >= {1'b0, r_sy}) && (w_y_ext < w_y_end);
    assign w_in_win    = r_busy && vi_de && !w_vs_rise && w_in_x && w_in_y;
    assign w_line_last = (w_x_ext + c_ONE) == w_x_end;
    assign w_last_line = (w_y_ext + c_ONE) == w_y_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d       <= 1'b0;
            r_de_d       <= 1'b0;
            r_sx         <= '0;
            r_sy         <= '0;
            r_sw         <= '0;
            r_sh         <= '0;
            r_busy       <= 1'b0;
            r_x_cnt      <= '0;
            r_y_cnt      <= '0;
            r_hold_vld   <= 1'b0;
            r_hold_data  <= '0;
            r_first      <= 1'b0;
            r_frame_done <= 1'b0;
            r_wd_vld     <= 1'b0;
            r_wd_data    <= '0;
            r_wd_sof     <= 1'b0;
            r_wd_eol     <= 1'b0;
            r_wd_last    <= 1'b0;
        end else begin
            r_vs_d       <= vi_vs;
            r_de_d       <= vi_de;
            r_wd_vld     <= 1'b0;
            // Fires on the write attempt of the final word, even if dropped
            r_frame_done <= r_wd_vld && r_wd_last;

            if (w_vs_rise) begin
                r_sx       <= win_x;
                r_sy       <= win_y;
                r_sw       <= win_w;
                r_sh       <= win_h;
                r_busy     <= capture_en;
                r_x_cnt    <= '0;
                r_y_cnt    <= '0;
                r_hold_vld <= 1'b0;
                r_first    <= 1'b1;
            end else begin
                if (vi_de) begin
                    r_x_cnt <= r_x_cnt + CW'(1);
                end else if (w_de_fall) begin
                    r_x_cnt    <= '0;
                    r_y_cnt    <= r_y_cnt + CW'(1);
                    // A line cut short by the frame edge never pairs across lines
                    r_hold_vld <= 1'b0;
                end

                if (w_in_win) begin
                    if (r_hold_vld || w_line_last) begin
                        r_wd_vld   <= 1'b1;
                        r_wd_data  <= r_hold_vld ? {vi_data, r_hold_data}
                                                 : {16'h0000, vi_data};
                        r_wd_sof   <= r_first;
                        r_wd_eol   <= w_line_last;
                        r_wd_last  <= w_line_last && w_last_line;
                        r_hold_vld <= 1'b0;
                        r_first    <= 1'b0;
                    end else begin
                        r_hold_vld  <= 1'b1;
                        r_hold_data <= vi_data;
                    end
                end

                if (r_wd_vld && r_wd_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign frame_done = r_frame_done;
    assign busy       = r_busy;

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO: {sof, eol, data}
    // ------------------------------------------------------------------
    logic [33:0]        r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_empty;
    logic               w_rd;
    logic               w_wr;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_rd    = !w_empty && m_ready;
    // A read in the same cycle frees the slot the write lands in
    assign w_wr    = r_wd_vld && (!w_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_wd_sof, r_wd_eol, r_wd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_vs_rise) begin
                r_overflow <= 1'b0;
            end else if (r_wd_vld && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign m_valid  = !w_empty;
    assign overflow = r_overflow;
    assign {m_sof, m_eol, m_data} = m_valid ? r_mem[r_rd_ptr] : 34'd0;

endmodule
`default_nettype wire

// File: tb/tb_vi_crop_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_vi_crop_pack
// Purpose  : Scoreboard bench for vi_crop_pack (4-word FIFO instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vi_crop_pack;

    localparam int c_AW = 2;
    localparam int c_CW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            vi_vs;
    logic            vi_de;
    logic [15:0]     vi_data;
    logic            capture_en;
    logic [c_CW-1:0] win_x;
    logic [c_CW-1:0] win_y;
    logic [c_CW-1:0] win_w;
    logic [c_CW-1:0] win_h;
    logic [31:0]     m_data;
    logic            m_sof;
    logic            m_eol;
    logic            m_valid;
    logic            m_ready;
    logic            frame_done;
    logic            overflow;
    logic            busy;

    vi_crop_pack #(.FIFO_AW(c_AW), .CW(c_CW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .vi_vs      (vi_vs),
        .vi_de      (vi_de),
        .vi_data    (vi_data),
        .capture_en (capture_en),
        .win_x      (win_x),
        .win_y      (win_y),
        .win_w      (win_w),
        .win_h      (win_h),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_done (frame_done),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          pix_cyc  = 0;
    int          done_cnt = 0;
    bit          lat_armed = 1'b0;
    logic [33:0] exp_q[$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word
    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            check("busy_at_done", busy, 0);
        end
        if (m_valid && lat_armed) begin
            check("first_valid_latency", cyc - pix_cyc, 2);
            lat_armed = 1'b0;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word_q_size", exp_q.size(), 1);
            end else begin
                check("word", {m_sof, m_eol, m_data}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pix(input int x, input int y);
        return 16'(16'h0100 + x + 16 * y);
    endfunction

    // Reference packing of one frame into the scoreboard (first cap words kept)
    task automatic model(input int wx, input int wy, input int ww, input int wh, input int cap);
        bit          held  = 1'b0;
        bit          first = 1'b1;
        logic [15:0] hp    = '0;
        logic [31:0] w;
        int          n     = 0;
        for (int yy = wy; yy < wy + wh; yy++) begin
            held = 1'b0;
            for (int xx = wx; xx < wx + ww; xx++) begin
                if (!held && xx != wx + ww - 1) begin
                    hp   = pix(xx, yy);
                    held = 1'b1;
                end else begin
                    w = held ? {pix(xx, yy), hp} : {16'h0000, pix(xx, yy)};
                    if (n < cap) exp_q.push_back({first, (xx == wx + ww - 1), w});
                    n++;
                    first = 1'b0;
                    held  = 1'b0;
                end
            end
        end
    endtask

    task automatic drive_frame(input int fw, input int fh, input int wx, input int wy,
                               input int ww, input int wh, input bit ce,
                               input int cap, input bit late_ce);
        win_x = c_CW'(wx); win_y = c_CW'(wy); win_w = c_CW'(ww); win_h = c_CW'(wh);
        capture_en = ce;
        if (ce && ww > 0 && wh > 0) model(wx, wy, ww, wh, cap);
        vi_de = 1'b0;
        vi_vs = 1'b1;
        tick(); tick();
        vi_vs = 1'b0;
        if (late_ce) capture_en = 1'b1;
        tick(); tick();
        for (int y = 0; y < fh; y++) begin
            for (int x = 0; x < fw; x++) begin
                vi_de   = 1'b1;
                vi_data = pix(x, y);
                if (x == wx + 1 && y == wy) pix_cyc = cyc;
                tick();
            end
            vi_de = 1'b0;
            tick(); tick(); tick();
        end
        repeat (4) tick();
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 200) begin
            tick();
            t++;
        end
        check("drain_q_size", exp_q.size(), 0);
        check("drain_valid", m_valid, 0);
    endtask

    int d0;

    initial begin
        rst = 1'b1; vi_vs = 1'b0; vi_de = 1'b0; vi_data = '0; capture_en = 1'b0;
        win_x = '0; win_y = '0; win_w = '0; win_h = '0; m_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", m_valid, 0);
        check("rst_data", {m_sof, m_eol, m_data}, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        rst = 1'b0;
        tick();

        // Basic 4x2 window inside an 8x4 frame, with latency check
        m_ready = 1'b1;
        d0 = done_cnt;
        lat_armed = 1'b1;
        drive_frame(8, 4, 2, 1, 4, 2, 1'b1, 99, 1'b0);
        wait_drain();
        check("A_done", done_cnt - d0, 1);
        check("A_busy", busy, 0);
        check("A_lat_seen", lat_armed, 0);

        // Odd width: last pixel padded
        d0 = done_cnt;
        drive_frame(4, 2, 0, 0, 3, 1, 1'b1, 99, 1'b0);
        wait_drain();
        check("B_done", done_cnt - d0, 1);

        // Overflow: 12 words into a 4-deep FIFO with the consumer stalled
        m_ready = 1'b0;
        d0 = done_cnt;
        drive_frame(8, 3, 0, 0, 8, 3, 1'b1, 4, 1'b0);
        check("C_overflow", overflow, 1);
        check("C_done", done_cnt - d0, 1);
        check("C_valid", m_valid, 1);
        m_ready = 1'b1;
        wait_drain();
        check("C_overflow_held", overflow, 1);

        // capture_en low at frame start, raised mid-frame
        d0 = done_cnt;
        drive_frame(8, 4, 2, 1, 4, 2, 1'b0, 99, 1'b1);
        check("D_overflow_cleared", overflow, 0);
        check("D_busy", busy, 0);
        check("D_done", done_cnt - d0, 0);
        check("D_valid", m_valid, 0);
        d0 = done_cnt;
        drive_frame(8, 4, 2, 1, 4, 2, 1'b1, 99, 1'b0);
        wait_drain();
        check("D_next_done", done_cnt - d0, 1);

        // vs_rise mid-line with one pixel held
        win_x = '0; win_y = '0; win_w = c_CW'(4); win_h = c_CW'(1); capture_en = 1'b1;
        vi_vs = 1'b1; tick(); vi_vs = 1'b0; tick(); tick();
        vi_de = 1'b1; vi_data = 16'hDEAD; tick();
        d0 = done_cnt;
        drive_frame(6, 2, 0, 0, 4, 1, 1'b1, 99, 1'b0);
        wait_drain();
        check("E_done", done_cnt - d0, 1);

        // Reset with words stored and the consumer stalled
        m_ready = 1'b0;
        drive_frame(6, 1, 0, 0, 6, 2, 1'b1, 0, 1'b0);
        check("F_pre_valid", m_valid, 1);
        check("F_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("F_rst_valid", m_valid, 0);
        check("F_rst_overflow", overflow, 0);
        check("F_rst_busy", busy, 0);
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (5) tick();
        check("F_post_valid", m_valid, 0);
        check("F_post_q", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
